// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the NPC sequencer: FSM state encoding,
// halt-cause codes and the default bus-wait limit.
package npc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } npc_state_t;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   localparam int NPC_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/npc_watchdog.sv
// Bus-wait watchdog: counts consecutive waiting cycles and flags expiry on the
// TIMEOUT_CYCLES-th one. Only instantiated when NPC_WATCHDOG_EN is defined.
module npc_watchdog
   import npc_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = NPC_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_waiting,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] r_cnt;

   // r_cnt holds the number of wait cycles already spent, so it is zero on
   // entry to FETCH/MEM and the current cycle is wait number r_cnt+1.
   always_ff @(posedge clk) begin
      if (rst || !i_waiting) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_expired = i_waiting && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/npc_seq_ctrl.sv
// Multicycle IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT sequencer for the NPC core.
// Define NPC_WATCHDOG_EN to add the bus-wait watchdog (halt cause 3).
module npc_seq_ctrl
   import npc_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = NPC_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        ifu_req,
   input  logic        ifu_valid,
   input  logic [31:0] inst,
   output logic [31:0] ir,
   input  logic        unknown_code,
   input  logic        is_ebreak,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        dec_rf_wen,
   output logic        lsu_req,
   output logic        lsu_we,
   input  logic        lsu_done,
   output logic        rf_we,
   output logic        pc_we,
   output logic        halt,
   output logic [1:0]  halt_cause,
   output logic [63:0] inst_cnt
);

   npc_state_t  r_state;
   npc_state_t  w_state_nxt;
   logic [1:0]  r_cause;
   logic [1:0]  w_cause_nxt;
   logic [31:0] r_ir;
   logic        r_rf_we;
   logic        r_lsu_we;
   logic [63:0] r_inst_cnt;
   logic        w_timeout;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("npc_seq_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef NPC_WATCHDOG_EN
   logic w_waiting;

   assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);

   npc_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_waiting (w_waiting),
      .o_expired (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = r_cause;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_FETCH;
         end
         // Arriving valid/done beats a watchdog expiry in the same cycle.
         S_FETCH: begin
            if (ifu_valid) begin
               w_state_nxt = S_DECODE;
            end else if (w_timeout) begin
               w_state_nxt = S_HALT;
               w_cause_nxt = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (unknown_code) begin
               w_state_nxt = S_HALT;
               w_cause_nxt = CAUSE_ILLEGAL;
            end else if (is_ebreak) begin
               w_state_nxt = S_HALT;
               w_cause_nxt = CAUSE_EBREAK;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = (is_load || is_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (lsu_done) begin
               w_state_nxt = S_WB;
            end else if (w_timeout) begin
               w_state_nxt = S_HALT;
               w_cause_nxt = CAUSE_TIMEOUT;
            end
         end
         S_WB:    w_state_nxt = S_FETCH;
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Strobes that follow decoder inputs are registered one cycle ahead so no
   // input reaches an output combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cause    <= CAUSE_NONE;
         r_ir       <= '0;
         r_rf_we    <= 1'b0;
         r_lsu_we   <= 1'b0;
         r_inst_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cause  <= w_cause_nxt;
         r_rf_we  <= (w_state_nxt == S_WB) && dec_rf_wen;
         r_lsu_we <= (w_state_nxt == S_MEM) && is_store;
         if ((r_state == S_FETCH) && ifu_valid) begin
            r_ir <= inst;
         end
         if (r_state == S_WB) begin
            r_inst_cnt <= r_inst_cnt + 64'd1;
         end
      end
   end

   assign ifu_req    = (r_state == S_FETCH);
   assign lsu_req    = (r_state == S_MEM);
   assign pc_we      = (r_state == S_WB);
   assign halt       = (r_state == S_HALT);
   assign lsu_we     = r_lsu_we;
   assign rf_we      = r_rf_we;
   assign halt_cause = r_cause;
   assign ir         = r_ir;
   assign inst_cnt   = r_inst_cnt;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed bench for npc_seq_ctrl: per-cycle expected outputs are planned from
// instruction-level timing rules and compared every cycle, plus literal pins.
`timescale 1ns/1ps
module tb_npc_seq_ctrl;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        ifu_valid = 1'b0;
   logic [31:0] inst = '0;
   logic        unknown_code = 1'b0;
   logic        is_ebreak = 1'b0;
   logic        is_load = 1'b0;
   logic        is_store = 1'b0;
   logic        dec_rf_wen = 1'b0;
   logic        lsu_done = 1'b0;
   logic        ifu_req, lsu_req, lsu_we, rf_we, pc_we, halt;
   logic [1:0]  halt_cause;
   logic [31:0] ir;
   logic [63:0] inst_cnt;

   always #5 clk = ~clk;

   npc_seq_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .ifu_req      (ifu_req),
      .ifu_valid    (ifu_valid),
      .inst         (inst),
      .ir           (ir),
      .unknown_code (unknown_code),
      .is_ebreak    (is_ebreak),
      .is_load      (is_load),
      .is_store     (is_store),
      .dec_rf_wen   (dec_rf_wen),
      .lsu_req      (lsu_req),
      .lsu_we       (lsu_we),
      .lsu_done     (lsu_done),
      .rf_we        (rf_we),
      .pc_we        (pc_we),
      .halt         (halt),
      .halt_cause   (halt_cause),
      .inst_cnt     (inst_cnt)
   );

   // One entry per clock cycle: inputs to drive and outputs expected then.
   typedef struct {
      logic        rst, start, ifu_valid, done;
      logic [31:0] inst;
      logic        unk, ebk, ld, st, rfw;
      logic        chk;
      logic        ifu_req, lsu_req, lsu_we, rf_we, pc_we, halt;
      logic [1:0]  cause;
      logic [31:0] ir;
      logic [63:0] cnt;
   } cyc_t;

   cyc_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat_log[$];
   int          lsu_log[$];
   logic [31:0] m_ir = '0;
   logic [63:0] m_cnt = '0;
   logic [1:0]  m_cause = '0;
   bit          f_unk, f_ebk, f_ld, f_st, f_rfw;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic cyc_t blank(input bit flags);
      cyc_t c;
      c.rst = 1'b0;  c.start = 1'($urandom);  c.ifu_valid = 1'($urandom);
      c.done = 1'($urandom);  c.inst = $urandom;
      if (flags) begin
         c.unk = f_unk; c.ebk = f_ebk; c.ld = f_ld; c.st = f_st; c.rfw = f_rfw;
      end else begin
         c.unk = 1'($urandom); c.ebk = 1'($urandom); c.ld = 1'($urandom);
         c.st = 1'($urandom);  c.rfw = 1'($urandom);
      end
      c.chk = 1'b1;
      c.ifu_req = 0; c.lsu_req = 0; c.lsu_we = 0; c.rf_we = 0; c.pc_we = 0; c.halt = 0;
      c.cause = 2'd0; c.ir = m_ir; c.cnt = m_cnt;
      return c;
   endfunction

   task automatic do_reset();
      cyc_t c = blank(0);
      c.rst = 1'b1; c.chk = 1'b0;
      q.push_back(c);
      m_ir = '0; m_cnt = '0; m_cause = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_t c = blank(0);
         c.start = 1'b0; c.ifu_valid = 1'b1; c.done = 1'b1;
         q.push_back(c);
      end
   endtask

   task automatic start_cyc();
      cyc_t c = blank(0);
      c.start = 1'b1;
      q.push_back(c);
   endtask

   task automatic halt_tail(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_t c = blank(0);
         c.start = 1'b1; c.ifu_valid = 1'b1; c.done = 1'b1;
         c.halt = 1'b1; c.cause = m_cause;
         q.push_back(c);
      end
   endtask

   task automatic fetch_timeout(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_t c = blank(0);
         c.ifu_valid = 1'b0; c.ifu_req = 1'b1;
         q.push_back(c);
      end
      m_cause = 2'd3;
      halt_tail(4);
   endtask

   // Plans one instruction: fetch (fwait extra cycles), decode, then either a
   // halt or exec, optional mem (mwait extra cycles) and wb. abort_mem >= 0
   // replaces that mem cycle with a reset.
   task automatic instr(input logic [31:0] w, input bit unk, ebk, ld, st, rfw,
                        input int fwait, mwait, input int abort_mem = -1);
      cyc_t c;
      f_unk = unk; f_ebk = ebk; f_ld = ld; f_st = st; f_rfw = rfw;
      for (int i = 0; i <= fwait; i++) begin
         c = blank(0);
         c.ifu_valid = (i == fwait); c.ifu_req = 1'b1;
         if (i == fwait) c.inst = w;
         q.push_back(c);
      end
      m_ir = w;
      q.push_back(blank(1));
      if (unk || ebk) begin
         m_cause = unk ? 2'd2 : 2'd1;
         halt_tail(4);
         return;
      end
      q.push_back(blank(1));
      if (ld || st) begin
         for (int i = 0; i <= mwait; i++) begin
            c = blank(1);
            c.lsu_req = 1'b1; c.lsu_we = st; c.done = (i == mwait);
            if (i == abort_mem) begin
               c.rst = 1'b1; c.done = 1'b0;
               q.push_back(c);
               m_ir = '0; m_cnt = '0; m_cause = '0;
               return;
            end
            q.push_back(c);
         end
      end
      c = blank(1);
      c.pc_we = 1'b1; c.rf_we = rfw;
      q.push_back(c);
      m_cnt = m_cnt + 64'd1;
   endtask

   task automatic seg_begin();
      lat_log.delete(); lsu_log.delete();
      do_reset(); idle(2); start_cyc();
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("queue_drained", 64'(q.size()), 64'd0);
      q.delete();
      repeat (3) @(negedge clk);
   endtask

   // Drive/compare process, plus per-instruction latency measurement
   // (first ifu_req cycle through the pc_we cycle).
   initial begin : drv
      cyc_t c;
      int   t_rise;
      int   lsu_hi;
      logic prev_req;
      t_rise = 0; lsu_hi = 0; prev_req = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (ifu_req === 1'b1 && prev_req !== 1'b1) begin
            t_rise = cyc; lsu_hi = 0;
         end
         if (lsu_req === 1'b1) lsu_hi++;
         if (pc_we === 1'b1) begin
            lat_log.push_back(cyc - t_rise + 1);
            lsu_log.push_back(lsu_hi);
         end
         prev_req = ifu_req;
         if (q.size() > 0) begin
            c = q.pop_front();
            if (c.chk) begin
               chk("ifu_req", 64'(ifu_req), 64'(c.ifu_req));
               chk("lsu_req", 64'(lsu_req), 64'(c.lsu_req));
               chk("lsu_we", 64'(lsu_we), 64'(c.lsu_we));
               chk("rf_we", 64'(rf_we), 64'(c.rf_we));
               chk("pc_we", 64'(pc_we), 64'(c.pc_we));
               chk("halt", 64'(halt), 64'(c.halt));
               chk("halt_cause", 64'(halt_cause), 64'(c.cause));
               chk("ir", 64'(ir), 64'(c.ir));
               chk("inst_cnt", inst_cnt, c.cnt);
            end
            rst = c.rst; start = c.start; ifu_valid = c.ifu_valid; inst = c.inst;
            unknown_code = c.unk; is_ebreak = c.ebk; is_load = c.ld; is_store = c.st;
            dec_rf_wen = c.rfw; lsu_done = c.done;
         end else begin
            rst = 1'b0; start = 1'b0; ifu_valid = 1'b0; lsu_done = 1'b0;
         end
      end
   end

   initial begin : guard
      #100000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "bench time limit reached");
   end

   initial begin : main
      // addi with one fetch wait cycle, then ebreak
      seg_begin();
      instr(32'h00000413, 0, 0, 0, 0, 1, 1, 0);
      instr(32'h00100073, 0, 1, 0, 0, 0, 0, 0);
      drain();
      chk("s1_halt", 64'(halt), 64'd1);
      chk("s1_cause", 64'(halt_cause), 64'd1);
      chk("s1_inst_cnt", inst_cnt, 64'd1);
      chk("s1_ir", 64'(ir), 64'h00100073);
      chk("s1_addi_latency", 64'(lat_log[0]), 64'd5);

      // reset out of HALT
      do_reset(); idle(2);
      drain();
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_cause", 64'(halt_cause), 64'd0);
      chk("rst_ir", 64'(ir), 64'd0);
      chk("rst_inst_cnt", inst_cnt, 64'd0);
      chk("rst_ifu_req", 64'(ifu_req), 64'd0);

      // load with done on 3rd mem cycle, store after 2 fetch waits, illegal+ebreak
      seg_begin();
      instr(32'h00003403, 0, 0, 1, 0, 1, 0, 2);
      instr(32'h00812023, 0, 0, 0, 1, 0, 2, 0);
      instr(32'hFFFFFFFF, 1, 1, 0, 0, 1, 0, 0);
      drain();
      chk("s2_ld_latency", 64'(lat_log[0]), 64'd7);
      chk("s2_ld_lsu_cycles", 64'(lsu_log[0]), 64'd3);
      chk("s2_sw_latency", 64'(lat_log[1]), 64'd7);
      chk("s2_sw_lsu_cycles", 64'(lsu_log[1]), 64'd1);
      chk("s2_cause", 64'(halt_cause), 64'd2);
      chk("s2_inst_cnt", inst_cnt, 64'd2);

      // reset in the third mem cycle, stray done/valid afterwards
      seg_begin();
      instr(32'h00812023, 0, 0, 0, 1, 0, 0, 5, 2);
      idle(4);
      drain();
      chk("s3_lsu_req", 64'(lsu_req), 64'd0);
      chk("s3_ifu_req", 64'(ifu_req), 64'd0);
      chk("s3_inst_cnt", inst_cnt, 64'd0);
      chk("s3_retired", 64'(lat_log.size()), 64'd0);

`ifdef NPC_WATCHDOG_EN
      // valid on the 8th wait cycle wins; then 8 idle wait cycles time out
      seg_begin();
      instr(32'h00000413, 0, 0, 0, 0, 1, TMO - 1, 0);
      fetch_timeout(TMO);
      drain();
      chk("s4_cause", 64'(halt_cause), 64'd3);
      chk("s4_inst_cnt", inst_cnt, 64'd1);
      chk("s4_latency", 64'(lat_log[0]), 64'd11);
      chk("s4_ifu_req", 64'(ifu_req), 64'd0);
`else
      // long fetch and memory waits never time out
      seg_begin();
      instr(32'h00000013, 0, 0, 0, 0, 0, 40, 0);
      instr(32'h00002403, 0, 0, 1, 0, 1, 0, 30);
      instr(32'h00100073, 0, 1, 0, 0, 0, 0, 0);
      drain();
      chk("s4_cause", 64'(halt_cause), 64'd1);
      chk("s4_inst_cnt", inst_cnt, 64'd2);
      chk("s4_nop_latency", 64'(lat_log[0]), 64'd44);
      chk("s4_lw_latency", 64'(lat_log[1]), 64'd35);
      chk("s4_lw_lsu_cycles", 64'(lsu_log[1]), 64'd31);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
